spi_target_mem: RTL and testbench
=================================

Name: spi_target_mem

Overview:
- SPI mode-0 target (responder) with a 256-byte internal memory. It is the far end of the SoC's SPI master pins: SPI_CLK, SPI_MOSI and SPI_CS feed this block, and its MISO output drives back to SPI_MISO.
- Used as an on-board loopback peripheral and as the bench partner for the SoC SPI master.
- The SPI pins are oversampled in the system clock domain, so there is no second clock.
- A side read port lets the host or testbench inspect memory contents.

Parameters:
- ID_BYTE, 8'hA5, value returned repeatedly for command 0x9F.
- SYNC_STAGES, 2, synchronizer depth on SCK, CS_N and MOSI (minimum 2).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- spi_sck  input  1  SPI clock from the master. Idle level is low (mode 0).
- spi_cs_n  input  1  chip select, active low.
- spi_mosi  input  1  master-out data.
- spi_miso  output  1  target-out data.
- busy  output  1  high while a transaction is active (CS low and synchronized).
- wr_strobe  output  1  one-cycle pulse on each memory write.
- host_addr  input  8  side-port read address.
- host_rdata  output  8  mem[host_addr], registered, 1-cycle latency.

Behaviour:
- Reset (asynchronous):
  - Outputs: spi_miso=0, busy=0, wr_strobe=0, host_rdata=0.
  - State: FSM=IDLE, bit counter=0, shift registers=0, address=0.
  - Memory contents are not cleared.
- Input synchronization:
  - SCK, CS_N and MOSI each pass through SYNC_STAGES flops.
  - Edge detection uses one extra flop on SCK and CS_N: rise = sync & ~prev, fall = ~sync & prev.
- Timing limits:
  - Requires SCK high and low phases of at least 3 clk each; faster SCK is unsupported.
  - Bus latency from a pin change to internal action is SYNC_STAGES+1 clk.
- Bit handling:
  - MOSI is sampled on each SCK rise, MSB first, into an 8-bit RX shift register.
  - A 3-bit counter tracks position; a byte completes on the 8th rise, and the counter wraps 7→0.
  - spi_miso changes only on SCK fall, or on CS fall for bit 7 of the first byte (always 0).
  - On a fall with counter==0 (byte boundary), the TX register loads the next byte and drives its bit 7. Otherwise TX shifts left and drives the new MSB.
- FSM states: IDLE, CMD, ADDR, RD, WR, ID, IGNORE.
  - IDLE→CMD on CS fall; busy goes high on the same cycle.
  - In CMD, the completed byte selects the next state: 0x03→ADDR(read), 0x02→ADDR(write), 0x9F→ID, any other value→IGNORE.
  - In ADDR, the completed byte loads the address register, then the FSM moves to RD or WR. For RD, the memory is read the next clk, ahead of the following SCK fall.
  - RD:
    - The TX load value is mem[addr].
    - After each load, addr increments, and the next byte's memory read happens on the following clk.
  - WR:
    - Each completed byte writes mem[addr] <= rx; wr_strobe pulses for 1 clk.
    - addr then increments.
  - ID: the TX load value is ID_BYTE for every byte.
  - IGNORE: all MOSI is discarded and MISO is driven 0 until CS rises.
  - TX load value is 0 in CMD, ADDR, IGNORE and IDLE.
- Address wrap: addr increments 8'hFF→8'h00 in both RD and WR.
- CS rise in any state (abort or normal end):
  - Next clk: FSM→IDLE, counter=0, spi_miso=0, busy=0.
  - A partial byte is discarded with no write. Only completed bytes are written.
- Simultaneous events:
  - If a CS rise coincides with an SCK rise that would complete a byte, CS wins and no write occurs.
  - If a side-port read and an SPI write hit the same address in the same clk, host_rdata returns the old data.

Test Plan:
- Write then read:
  - Stimulus: CS low, send 02 10 DE AD, CS high; then CS low, send 03 10 00 00, CS high.
  - Response: MISO bytes 00 00 DE AD; wr_strobe pulses exactly twice.
  - Side port: host_addr=8'h11 → host_rdata=8'hAD one clk later.
- Address wrap:
  - Stimulus: send 02 FF 11 22, then 03 FF 00 00.
  - Response: mem[FF]=11 and mem[00]=22; the read returns 11 22.
- ID command:
  - Stimulus: send 9F 00 00 00.
  - Response: MISO 00 A5 A5 A5 (with the default ID_BYTE).
- Unknown command:
  - Stimulus: send 5A 02 33.
  - Response: no wr_strobe; MISO stays 0; memory unchanged.
- Abort mid-byte:
  - Stimulus: send 02 20, then 4 bits of 0xFF, then CS high.
  - Response: mem[20] unchanged; busy=0 within SYNC_STAGES+2 clk; the next transaction decodes correctly.
- Async reset during an RD transfer:
  - Response: spi_miso=0 and busy=0 immediately, without waiting for a clk edge.
  - After reset releases with CS still low, the FSM stays IDLE until the next CS fall.

Source files
------------

// File: rtl/spi_target_mem.sv
// SPI mode-0 target with a 256-byte memory; the SPI pins are oversampled on clk.
// A registered side port lets the host read any memory location.
//
// state  | meaning
// IDLE   | CS high (or not yet seen falling), waiting for CS fall
// CMD    | receiving the command byte
// ADDR   | receiving the start address for a read or write
// RD     | streaming mem[addr++] out on MISO
// WR     | writing each completed MOSI byte to mem[addr++]
// ID     | returning ID_BYTE for every byte
// IGNORE | unknown command, discard everything until CS rises
module spi_target_mem #(
    parameter logic [7:0] ID_BYTE     = 8'hA5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       busy,
    output logic       wr_strobe,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_ID, S_IGNORE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_prev, cs_prev;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_rise, cs_fall;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_sr, tx_sr, addr, rd_buf, load_val, rx_next;
    logic                   is_wr, byte_done, mem_we;
    logic [7:0]             mem [256];

    // CS sync flops reset low so a CS already low at reset release is not seen as a fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    assign rx_next   = {rx_sr[6:0], mosi_s};
    assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state != S_IDLE) && !cs_rise;
    assign mem_we    = byte_done && (state == S_WR);

    always_comb begin
        load_val = 8'h00;
        case (state)
            S_RD:    load_val = rd_buf;
            S_ID:    load_val = ID_BYTE;
            default: load_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= 3'd0;
            rx_sr     <= 8'h00;
            tx_sr     <= 8'h00;
            addr      <= 8'h00;
            is_wr     <= 1'b0;
            spi_miso  <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= mem_we;
            if (cs_rise) begin
                state    <= S_IDLE;
                bit_cnt  <= 3'd0;
                spi_miso <= 1'b0;
                busy     <= 1'b0;
            end else if (state == S_IDLE) begin
                if (cs_fall) begin
                    state    <= S_CMD;
                    busy     <= 1'b1;
                    bit_cnt  <= 3'd0;
                    rx_sr    <= 8'h00;
                    tx_sr    <= 8'h00;
                    spi_miso <= 1'b0;
                end
            end else begin
                if (sck_rise) begin
                    rx_sr   <= rx_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            S_CMD: begin
                                case (rx_next)
                                    8'h03: begin state <= S_ADDR; is_wr <= 1'b0; end
                                    8'h02: begin state <= S_ADDR; is_wr <= 1'b1; end
                                    8'h9F: state <= S_ID;
                                    default: state <= S_IGNORE;
                                endcase
                            end
                            S_ADDR: begin
                                addr  <= rx_next;
                                state <= is_wr ? S_WR : S_RD;
                            end
                            S_WR:    addr <= addr + 8'd1;
                            default: ;
                        endcase
                    end
                end
                if (sck_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_sr    <= load_val;
                        spi_miso <= load_val[7];
                        if (state == S_RD)
                            addr <= addr + 8'd1;
                    end else begin
                        tx_sr    <= {tx_sr[6:0], 1'b0};
                        spi_miso <= tx_sr[6];
                    end
                end
            end
        end
    end

    // rd_buf tracks mem[addr] every clk so the next RD byte is ready before the SCK fall.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr] <= rx_next;
        rd_buf <= mem[addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            host_rdata <= 8'h00;
        else
            host_rdata <= mem[host_addr];
    end

endmodule

// File: tb/tb_spi_target_mem.sv
// Directed bench for spi_target_mem: a table of SPI transactions with expected MISO
// bytes and write counts, plus hand sequences for abort, CS/SCK collision and reset.
module tb_spi_target_mem;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_sck, spi_cs_n, spi_mosi, spi_miso;
    logic       busy, wr_strobe;
    logic [7:0] host_addr, host_rdata;

    int         checks = 0;
    int         errors = 0;
    int         wr_total = 0;
    logic [7:0] rd_at_wr = 8'h00;

    localparam int HALF = 6;

    spi_target_mem #(.ID_BYTE(8'hA5), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .busy       (busy),
        .wr_strobe  (wr_strobe),
        .host_addr  (host_addr),
        .host_rdata (host_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            wr_total = wr_total + 1;
            rd_at_wr = host_rdata;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] tx;
        logic [31:0] exp_rx;
        int          nbytes;
        int          exp_wr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        clks(HALF);
        r = spi_miso;
        spi_sck = 1'b1;
        clks(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], rb);
            r[i] = rb;
        end
    endtask

    task automatic host_read(input string name, input logic [7:0] a, input logic [7:0] exp);
        host_addr = a;
        clks(1);
        check(name, 32'(host_rdata), 32'(exp));
    endtask

    task automatic run_xfer(input string name, input logic [31:0] tx, input logic [31:0] exp_rx,
                            input int nbytes, input int exp_wr);
        logic [7:0] r;
        int         wr0;
        wr0 = wr_total;
        spi_cs_n = 1'b0;
        clks(HALF);
        check({name, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < nbytes; k++) begin
            spi_byte(tx[31-8*k -: 8], r);
            check($sformatf("%s_b%0d", name, k), 32'(r), 32'(exp_rx[31-8*k -: 8]));
        end
        clks(HALF);
        spi_cs_n = 1'b1;
        clks(10);
        check({name, "_wr"}, 32'(wr_total - wr0), 32'(exp_wr));
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r;
        logic       rb;
        int         wr0;

        vecs[0] = '{"wr10",   32'h0210DEAD, 32'h00000000, 4, 2};
        vecs[1] = '{"rd10",   32'h03100000, 32'h0000DEAD, 4, 0};
        vecs[2] = '{"wrwrap", 32'h02FF1122, 32'h00000000, 4, 2};
        vecs[3] = '{"rdwrap", 32'h03FF0000, 32'h00001122, 4, 0};
        vecs[4] = '{"id",     32'h9F000000, 32'h00A5A5A5, 4, 0};
        vecs[5] = '{"wr02",   32'h02027700, 32'h00000000, 3, 1};
        vecs[6] = '{"unk",    32'h5A023300, 32'h00000000, 3, 0};
        vecs[7] = '{"wr20",   32'h02205500, 32'h00000000, 3, 1};
        vecs[8] = '{"wr40",   32'h02406600, 32'h00000000, 3, 1};

        reset     = 1'b1;
        spi_sck   = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        host_addr = 8'h00;
        clks(3);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wrs", 32'(wr_strobe), 32'd0);
        check("rst_hrd", 32'(host_rdata), 32'd0);
        reset = 1'b0;
        clks(5);

        for (int v = 0; v < 9; v++)
            run_xfer(vecs[v].name, vecs[v].tx, vecs[v].exp_rx, vecs[v].nbytes, vecs[v].exp_wr);

        host_read("host_11", 8'h11, 8'hAD);
        host_read("host_10", 8'h10, 8'hDE);
        host_read("host_ff", 8'hFF, 8'h11);
        host_read("host_00", 8'h00, 8'h22);
        host_read("host_02", 8'h02, 8'h77);

        // abort mid-byte after 02 20 + four bits
        wr0 = wr_total;
        spi_cs_n = 1'b0;
        clks(HALF);
        spi_byte(8'h02, r);
        spi_byte(8'h20, r);
        for (int i = 0; i < 4; i++)
            spi_bit(1'b1, rb);
        clks(HALF);
        spi_cs_n = 1'b1;
        clks(4);
        check("abort_busy", 32'(busy), 32'd0);
        clks(6);
        check("abort_wr", 32'(wr_total - wr0), 32'd0);
        host_read("abort_mem20", 8'h20, 8'h55);
        run_xfer("post_abort", 32'h9F000000, 32'h00A50000, 2, 0);

        // CS rise lands on the same cycle as the byte-completing SCK rise
        wr0 = wr_total;
        spi_cs_n = 1'b0;
        clks(HALF);
        spi_byte(8'h02, r);
        spi_byte(8'h40, r);
        for (int i = 0; i < 7; i++)
            spi_bit(1'b1, rb);
        spi_mosi = 1'b1;
        clks(HALF);
        spi_sck  = 1'b1;
        spi_cs_n = 1'b1;
        clks(HALF);
        spi_sck = 1'b0;
        clks(10);
        check("coll_wr", 32'(wr_total - wr0), 32'd0);
        check("coll_busy", 32'(busy), 32'd0);
        host_read("coll_mem40", 8'h40, 8'h66);

        // side-port read of the address being written returns the old data
        host_addr = 8'h20;
        clks(2);
        run_xfer("same_addr", 32'h02209900, 32'h00000000, 3, 1);
        check("same_addr_old", 32'(rd_at_wr), 32'h55);
        host_read("same_addr_new", 8'h20, 8'h99);

        // async reset in the middle of an RD transfer
        spi_cs_n = 1'b0;
        clks(HALF);
        spi_byte(8'h03, r);
        spi_byte(8'h10, r);
        clks(4);
        check("rd_pre_rst_miso", 32'(spi_miso), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_miso", 32'(spi_miso), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_hrd", 32'(host_rdata), 32'd0);
        clks(3);
        reset = 1'b0;
        clks(10);
        check("post_rst_idle", 32'(busy), 32'd0);
        spi_byte(8'h9F, r);
        check("post_rst_miso", 32'(r), 32'd0);
        check("post_rst_still_idle", 32'(busy), 32'd0);
        spi_cs_n = 1'b1;
        clks(10);
        run_xfer("after_reset", 32'h03100000, 32'h0000DE00, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
